// File: rtl/mem_responder_if.sv
// Memory bus between an initiator (master) and the mem_responder (slave).
//
// Handshake: the initiator raises mem_valid_i and holds mem_valid_i,
// mem_addr_i, mem_wdata_i and mem_we_i stable until the cycle in which
// mem_ready_o=1. mem_ready_o is a one-cycle completion strobe. The transfer
// completes in that cycle, and the responder samples the request again at the
// edge that ends it. mem_rdata_o and mem_err_o are meaningful while
// mem_ready_o=1. mem_we_i=0 is a read; any nonzero mem_we_i is a byte-masked
// write.
interface mem_responder_if;
  logic        mem_valid_i;
  logic        mem_ready_o;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_we_i;
  logic [31:0] mem_rdata_o;
  logic        mem_err_o;

  modport master (
    output mem_valid_i, mem_addr_i, mem_wdata_i, mem_we_i,
    input  mem_ready_o, mem_rdata_o, mem_err_o
  );

  modport slave (
    input  mem_valid_i, mem_addr_i, mem_wdata_i, mem_we_i,
    output mem_ready_o, mem_rdata_o, mem_err_o
  );
endinterface

// File: rtl/mem_responder.sv
// Single-port word memory acting as the responder on the core memory bus.
// Latency is configurable, and an LFSR can inject 0..3 extra wait cycles per
// transfer. Out-of-range accesses complete with mem_err_o. Completed reads and
// writes are counted. Memory contents survive reset and are never cleared.
module mem_responder #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0,
  parameter int unsigned DEPTH_WORDS  = 4096,
  parameter int unsigned LATENCY      = 1,
  parameter bit          RANDOM_STALL = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_responder_if.slave      bus,
  output logic [31:0]         rd_count_o,
  output logic [31:0]         wr_count_o,
  output logic [1:0]          state_o,
  output logic [4:0]          wait_cnt_o
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state;
  logic [4:0]       wait_cnt;
  logic [15:0]      lfsr;
  logic             err_q;
  logic [31:0]      rdata_q;
  logic [31:0]      mem [DEPTH_WORDS];

  logic [31:0]      offset;
  logic [29:0]      word_off;
  logic             in_range;
  logic [IDX_W-1:0] index;
  logic [1:0]       extra;
  logic [4:0]       wait_init;
  logic             enter_resp;
  logic             is_write;
  logic             lfsr_fb;
  logic             unused_addr_bits;

  // Unsigned subtraction makes addresses below the base wrap to huge indices,
  // so they fall out of range naturally.
  assign offset           = bus.mem_addr_i - BASE_ADDRESS;
  assign word_off         = offset[31:2];
  assign unused_addr_bits = ^offset[1:0];
  assign in_range         = ({2'b00, word_off} < 32'(DEPTH_WORDS));
  assign index            = word_off[IDX_W-1:0];
  assign is_write         = |bus.mem_we_i;

  // Wait-cycle count for a new request: fixed latency plus optional stall.
  assign extra     = RANDOM_STALL ? lfsr[1:0] : 2'b00;
  assign wait_init = 5'(LATENCY - 1) + {3'b000, extra};

  // Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  assign enter_resp = bus.mem_valid_i &&
                      (((state == S_IDLE) && (wait_init == 5'd0)) ||
                       ((state == S_WAIT) && (wait_cnt == 5'd1)));

  // Ready is decoded purely from state so it never follows inputs combinationally.
  assign bus.mem_ready_o = (state == S_RESP);
  assign bus.mem_err_o   = (state == S_RESP) & err_q;
  assign bus.mem_rdata_o = rdata_q;

  assign state_o    = state;
  assign wait_cnt_o = wait_cnt;

  // Request sequencing: IDLE -> (WAIT) -> RESP -> IDLE, with abort out of WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= 5'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.mem_valid_i) begin
            if (wait_init == 5'd0) begin
              state <= S_RESP;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= wait_init;
            end
          end
        end
        S_WAIT: begin
          if (!bus.mem_valid_i) begin
            state    <= S_IDLE;
            wait_cnt <= 5'd0;
          end else if (wait_cnt == 5'd1) begin
            state    <= S_RESP;
            wait_cnt <= 5'd0;
          end else begin
            wait_cnt <= wait_cnt - 5'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          wait_cnt <= 5'd0;
        end
      endcase
    end
  end

  // Stall generator advances once per accepted request, only when stalls are enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else if (RANDOM_STALL && (state == S_IDLE) && bus.mem_valid_i) begin
      lfsr <= {lfsr_fb, lfsr[15:1]};
    end
  end

  // Read data and range flag are captured on the edge that enters RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      rdata_q <= in_range ? mem[index] : 32'h0;
      err_q   <= ~in_range;
    end
  end

  // Transfer counters step on the edge that ends RESP, including out-of-range ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_o <= 32'd0;
      wr_count_o <= 32'd0;
    end else if (state == S_RESP) begin
      if (is_write) begin
        wr_count_o <= wr_count_o + 32'd1;
      end else begin
        rd_count_o <= rd_count_o + 32'd1;
      end
    end
  end

  // Byte-lane write commit at the end of RESP; reset forces IDLE so none happens then.
  always_ff @(posedge clk) begin
    if ((state == S_RESP) && is_write && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.mem_we_i[i]) begin
          mem[index][8*i +: 8] <= bus.mem_wdata_i[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: four instances with different latency/stall/base
// settings, a directed vector table, multi-cycle corner sequences and a
// randomized run against a word-array memory model.
module tb_mem_responder;

  localparam logic [31:0] RBASE = 32'h1000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic [3:0]        rst_n;
  logic [3:0]        valid;
  logic [3:0]        ready;
  logic [3:0]        err;
  logic [3:0][31:0]  addr;
  logic [3:0][31:0]  wdata;
  logic [3:0][31:0]  rdata;
  logic [3:0][3:0]   we;
  logic [3:0][31:0]  rd_cnt;
  logic [3:0][31:0]  wr_cnt;
  logic [3:0][1:0]   dbg_state_unused;
  logic [3:0][4:0]   dbg_wait_unused;

  // 0: LATENCY=1, 1: LATENCY=4, 2: LATENCY=6, 3: LATENCY=1 with stalls, base RBASE
  for (genvar g = 0; g < 4; g++) begin : g_dut
    mem_responder_if bus ();
    assign bus.mem_valid_i = valid[g];
    assign bus.mem_addr_i  = addr[g];
    assign bus.mem_wdata_i = wdata[g];
    assign bus.mem_we_i    = we[g];
    assign ready[g]        = bus.mem_ready_o;
    assign err[g]          = bus.mem_err_o;
    assign rdata[g]        = bus.mem_rdata_o;

    mem_responder #(
      .BASE_ADDRESS (g == 3 ? RBASE : 32'h0),
      .DEPTH_WORDS  (4096),
      .LATENCY      (g == 1 ? 4 : (g == 2 ? 6 : 1)),
      .RANDOM_STALL (g == 3)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .bus        (bus),
      .rd_count_o (rd_cnt[g]),
      .wr_count_o (wr_cnt[g]),
      .state_o    (dbg_state_unused[g]),
      .wait_cnt_o (dbg_wait_unused[g])
    );
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    bit          chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts at posedge+1 of the request's cycle 0; returns at posedge+1 of the
  // cycle after ready, once any write has been committed.
  task automatic xfer(input int d, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input bit keep,
                      output logic [31:0] rd, output logic er, output int lat,
                      output int unsigned t_rdy);
    valid[d] = 1'b1;
    addr[d]  = a;
    wdata[d] = wd;
    we[d]    = be;
    lat      = -1;
    rd       = 32'h0;
    er       = 1'b0;
    t_rdy    = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (ready[d]) begin
        lat   = k;
        rd    = rdata[d];
        er    = err[d];
        t_rdy = cyc;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: dut %0d addr %h got no ready within 40 cycles", d, a);
      valid[d] = 1'b0;
    end else begin
      @(posedge clk); #1;
      check($sformatf("ready_width_d%0d", d), 32'(ready[d]), 32'd0);
      if (!keep) valid[d] = 1'b0;
    end
  endtask

  task automatic test_directed();
    vec_t        tbl[13];
    logic [31:0] rd;
    logic        er;
    int          lat;
    int unsigned trdy;
    int          n_rd;
    int          n_wr;
    n_rd = 0;
    n_wr = 0;
    tbl[0]  = '{32'h10,       32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        1'b0};
    tbl[1]  = '{32'h10,       32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{32'h20,       32'h11223344, 4'hF, 1'b0, 32'h0,        1'b0};
    tbl[3]  = '{32'h20,       32'hAABBCCDD, 4'h5, 1'b0, 32'h0,        1'b0};
    tbl[4]  = '{32'h20,       32'h0,        4'h0, 1'b1, 32'h11BB33DD, 1'b0};
    tbl[5]  = '{32'h0,        32'h12345678, 4'hF, 1'b0, 32'h0,        1'b0};
    tbl[6]  = '{32'h4000,     32'h0,        4'h0, 1'b1, 32'h0,        1'b1};
    tbl[7]  = '{32'h4000,     32'h55555555, 4'hF, 1'b0, 32'h0,        1'b1};
    tbl[8]  = '{32'h0,        32'h0,        4'h0, 1'b1, 32'h12345678, 1'b0};
    tbl[9]  = '{32'h13,       32'h0,        4'h0, 1'b1, 32'hDEADBEEF, 1'b0};
    tbl[10] = '{32'hFFFFFFFC, 32'h0,        4'h0, 1'b1, 32'h0,        1'b1};
    tbl[11] = '{32'h3FFC,     32'hCAFEF00D, 4'hF, 1'b0, 32'h0,        1'b0};
    tbl[12] = '{32'h3FFC,     32'h0,        4'h0, 1'b1, 32'hCAFEF00D, 1'b0};
    for (int i = 0; i < 13; i++) begin
      xfer(0, tbl[i].a, tbl[i].wd, tbl[i].be, 1'b0, rd, er, lat, trdy);
      if (tbl[i].be == 4'h0) n_rd++;
      else n_wr++;
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_err));
      if (tbl[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("vec%0d_rd_count", i), rd_cnt[0], 32'(n_rd));
      check($sformatf("vec%0d_wr_count", i), wr_cnt[0], 32'(n_wr));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic        er;
    int          lat;
    int unsigned trdy;
    int unsigned t0;
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      xfer(1, 32'(i * 4), 32'h0, 4'h0, (i < 2), rd, er, lat, trdy);
      check($sformatf("b2b_ready_cycle%0d", i), trdy - t0, 32'(4 + 5 * i));
    end
    check("b2b_rd_count", rd_cnt[1], 32'd3);
  endtask

  task automatic test_abort_reset();
    logic [31:0] rd;
    logic        er;
    int          lat;
    int unsigned trdy;
    int          pulses;
    pulses   = 0;
    valid[2] = 1'b1;
    addr[2]  = 32'h8;
    wdata[2] = 32'h0;
    we[2]    = 4'h0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (ready[2]) pulses++;
      if (k == 2) valid[2] = 1'b0;
    end
    check("abort_no_ready", 32'(pulses), 32'd0);
    check("abort_rd_count", rd_cnt[2], 32'd0);
    check("abort_wr_count", wr_cnt[2], 32'd0);

    xfer(2, 32'h40, 32'hA5A5A5A5, 4'hF, 1'b0, rd, er, lat, trdy);
    check("l6_write_latency", 32'(lat), 32'd6);
    xfer(2, 32'h40, 32'h0, 4'h0, 1'b0, rd, er, lat, trdy);
    check("l6_read_latency", 32'(lat), 32'd6);
    check("l6_read_data", rd, 32'hA5A5A5A5);
    check("l6_counts", {rd_cnt[2][15:0], wr_cnt[2][15:0]}, 32'h0001_0001);

    valid[2] = 1'b1;
    addr[2]  = 32'h40;
    wdata[2] = 32'h5A5A5A5A;
    we[2]    = 4'hF;
    repeat (3) begin @(posedge clk); #1; end
    rst_n[2] = 1'b0;
    #1;
    check("midreset_ready", 32'(ready[2]), 32'd0);
    check("midreset_rdata", rdata[2], 32'h0);
    check("midreset_rd_count", rd_cnt[2], 32'd0);
    check("midreset_wr_count", wr_cnt[2], 32'd0);
    valid[2] = 1'b0;
    @(posedge clk); #1;
    rst_n[2] = 1'b1;
    @(posedge clk); #1;
    xfer(2, 32'h40, 32'h0, 4'h0, 1'b0, rd, er, lat, trdy);
    check("midreset_word_kept", rd, 32'hA5A5A5A5);
    check("midreset_rd_after", rd_cnt[2], 32'd1);
    check("midreset_wr_after", wr_cnt[2], 32'd0);
  endtask

  task automatic test_random();
    logic [31:0] model [16];
    int          lat_hist[$];
    bit          seen[5];
    logic [31:0] a, wd, off, rd;
    logic [3:0]  be;
    logic        er, in_rng;
    int          lat, n_rd, n_wr, distinct;
    int unsigned trdy, r, idx;
    bit          keep;
    n_rd = 0;
    n_wr = 0;
    for (int i = 0; i < 5; i++) seen[i] = 1'b0;

    for (int n = 0; n < 1016; n++) begin
      if (n < 16) begin
        a    = RBASE + 32'(n * 4);
        be   = 4'hF;
        keep = 1'b0;
      end else begin
        r   = $urandom_range(0, 9);
        idx = $urandom_range(0, 15);
        if (r == 0)      a = RBASE + 32'h4000 + (32'(idx) << 2);
        else if (r == 1) a = RBASE - 32'(4 * (1 + (idx % 4)));
        else             a = RBASE + (32'(idx) << 2) + 32'($urandom_range(0, 3));
        be   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        keep = 1'($urandom_range(0, 1));
      end
      wd = $urandom;
      xfer(3, a, wd, be, keep, rd, er, lat, trdy);
      lat_hist.push_back(lat);
      if (lat >= 1 && lat <= 4) seen[lat] = 1'b1;

      off    = a - RBASE;
      in_rng = (off >> 2) < 32'd4096;
      checks++;
      if (lat < 1 || lat > 4) begin
        failures++;
        $display("FAIL rand_latency: transfer %0d latency %0d expected 1..4", n, lat);
      end
      check($sformatf("rand%0d_err", n), 32'(er), 32'(!in_rng));
      if (be == 4'h0) begin
        n_rd++;
        check($sformatf("rand%0d_rdata", n), rd, in_rng ? model[off >> 2] : 32'h0);
      end else begin
        n_wr++;
        if (in_rng) begin
          for (int l = 0; l < 4; l++)
            if (be[l]) model[off >> 2][8*l +: 8] = wd[8*l +: 8];
        end
      end
      check($sformatf("rand%0d_counts", n), {rd_cnt[3][15:0], wr_cnt[3][15:0]},
            {16'(n_rd), 16'(n_wr)});
    end
    distinct = 0;
    for (int i = 1; i < 5; i++) if (seen[i]) distinct++;
    check("rand_stall_variety", 32'(distinct >= 3), 32'd1);

    rst_n[3] = 1'b0;
    valid[3] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("rand_reset_rd_count", rd_cnt[3], 32'd0);
    check("rand_reset_wr_count", wr_cnt[3], 32'd0);
    rst_n[3] = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 24; n++) begin
      xfer(3, RBASE + 32'((n % 16) * 4), 32'h0, 4'h0, 1'b0, rd, er, lat, trdy);
      check($sformatf("replay%0d_latency", n), 32'(lat), 32'(lat_hist[n]));
      check($sformatf("replay%0d_rdata", n), rd, model[n % 16]);
    end
  endtask

  initial begin
    rst_n = 4'h0;
    valid = 4'h0;
    addr  = '0;
    wdata = '0;
    we    = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      check($sformatf("reset_ready_d%0d", d), 32'(ready[d]), 32'd0);
      check($sformatf("reset_err_d%0d", d), 32'(err[d]), 32'd0);
      check($sformatf("reset_rdata_d%0d", d), rdata[d], 32'h0);
      check($sformatf("reset_rd_count_d%0d", d), rd_cnt[d], 32'd0);
      check($sformatf("reset_wr_count_d%0d", d), wr_cnt[d], 32'd0);
    end
    rst_n = 4'hF;
    @(posedge clk); #1;

    test_directed();
    test_back_to_back();
    test_abort_reset();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
